// File: rtl/elevator.sv
// Single-car elevator motion/door controller: Moore FSM with registered status output.
// Requests arriving while the door is open are held and serviced once it closes.
module elevator #(
  parameter int DOOR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       floor_status,
  input  logic [1:0] motion_status,
  output logic [2:0] out
);

  localparam int TW = $clog2(DOOR_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_UP   = 2'b01;
  localparam logic [1:0] REQ_DOWN = 2'b10;
  localparam logic [1:0] REQ_STOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_UP    = 3'b001,
    S_DOWN  = 3'b010,
    S_DOOR  = 3'b100,
    S_ESTOP = 3'b111
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    out_q, out_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = timer_q;

    case (state_q)
      S_IDLE: begin
        if (motion_status == REQ_STOP) begin
          state_d = S_ESTOP;
        end else if (motion_status == REQ_UP) begin
          state_d = S_UP;
        end else if (motion_status == REQ_DOWN) begin
          state_d = S_DOWN;
        end else if (pending_q == REQ_UP) begin
          state_d   = S_UP;
          pending_d = REQ_NONE;
        end else if (pending_q == REQ_DOWN) begin
          state_d   = S_DOWN;
          pending_d = REQ_NONE;
        end
      end

      S_UP, S_DOWN: begin
        // Emergency stop outranks arrival; direction changes are dropped while moving.
        if (motion_status == REQ_STOP) begin
          state_d = S_ESTOP;
        end else if (floor_status) begin
          state_d = S_DOOR;
          timer_d = TIMER_LOAD;
        end
      end

      S_DOOR: begin
        if (motion_status == REQ_STOP) begin
          state_d   = S_ESTOP;
          pending_d = REQ_NONE;
          timer_d   = '0;
        end else begin
          if (motion_status == REQ_UP || motion_status == REQ_DOWN) begin
            pending_d = motion_status;
          end
          if (timer_q == '0) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      S_ESTOP: begin
        pending_d = REQ_NONE;
        timer_d   = '0;
        if (motion_status == REQ_NONE) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        pending_d = REQ_NONE;
        timer_d   = '0;
      end
    endcase
  end

  // Output is decoded from the next state so it lands on the same edge as the state.
  always_comb begin
    out_d = 3'b000;
    case (state_d)
      S_IDLE:  out_d = 3'b000;
      S_UP:    out_d = 3'b001;
      S_DOWN:  out_d = 3'b010;
      S_DOOR:  out_d = 3'b100;
      S_ESTOP: out_d = 3'b111;
      default: out_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= REQ_NONE;
      timer_q   <= '0;
      out_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_elevator.sv
// Self-checking bench for elevator: expected out codes are queued as stimulus is
// driven and popped for comparison one time unit after each rising edge.
module tb_elevator;

  logic       clk;
  logic       rst_n;
  logic       floor_status;
  logic [1:0] motion_status;
  logic [2:0] out;

  int vectors;
  int miscompares;
  logic [2:0] exp_q[$];

  // Encoded stimulus word: {motion_status[1:0], floor_status, expected_out[2:0]}
  typedef logic [5:0] vec_t;

  elevator #(.DOOR_CYCLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .floor_status  (floor_status),
    .motion_status (motion_status),
    .out           (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic [1:0] ms, input logic fl, input logic [2:0] e);
    @(negedge clk);
    motion_status = ms;
    floor_status  = fl;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    rst_n         = 1'b0;
    motion_status = 2'bxx;
    floor_status  = 1'bx;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(3'b000);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: out=%b expected=%b", i, out, e);
      end
    end
    @(negedge clk);
    motion_status = 2'b00;
    floor_status  = 1'b0;
    rst_n         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 3'b000);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_release[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_move_and_door();
    vec_t v[6] = '{
      {2'b01, 1'b0, 3'b001}, {2'b00, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100},
      {2'b00, 1'b0, 3'b100}, {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL move_and_door[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_pending_request();
    vec_t v[10] = '{
      {2'b01, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100}, {2'b10, 1'b0, 3'b100},
      {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b010}, {2'b00, 1'b0, 3'b010},
      {2'b00, 1'b1, 3'b100}, {2'b00, 1'b0, 3'b100}, {2'b00, 1'b0, 3'b000},
      {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL pending_request[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_estop();
    vec_t v[15] = '{
      {2'b10, 1'b0, 3'b010}, {2'b11, 1'b1, 3'b111}, {2'b11, 1'b0, 3'b111},
      {2'b11, 1'b0, 3'b111}, {2'b11, 1'b0, 3'b111}, {2'b00, 1'b0, 3'b000},
      {2'b00, 1'b0, 3'b000},
      // door open with a latched up request, then stop: the request must vanish
      {2'b01, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100}, {2'b01, 1'b0, 3'b100},
      {2'b11, 1'b0, 3'b111}, {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b000},
      {2'b00, 1'b0, 3'b000},
      // stop straight from idle, direction requests ignored until released
      {2'b11, 1'b0, 3'b111}};
    vec_t tail[3] = '{
      {2'b01, 1'b0, 3'b111}, {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL estop[%0d]: out=%b expected=%b", i, out, e);
      end
    end
    foreach (tail[i]) begin
      drive(tail[i][5:4], tail[i][3], tail[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL estop_release[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_ignore_while_moving();
    vec_t v[8] = '{
      {2'b01, 1'b0, 3'b001}, {2'b10, 1'b0, 3'b001}, {2'b10, 1'b0, 3'b001},
      {2'b00, 1'b1, 3'b100}, {2'b00, 1'b0, 3'b100}, {2'b00, 1'b0, 3'b000},
      {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL ignore_while_moving[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_door_boundaries();
    // floor held high through the whole door cycle and into idle: no extension, no move
    vec_t v[6] = '{
      {2'b01, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100}, {2'b00, 1'b1, 3'b100},
      {2'b00, 1'b1, 3'b000}, {2'b00, 1'b1, 3'b000}, {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL door_boundaries[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    // latest request during the door cycle overwrites the earlier one
    vec_t v[9] = '{
      {2'b01, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100}, {2'b10, 1'b0, 3'b100},
      {2'b01, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b001}, {2'b00, 1'b1, 3'b100},
      {2'b00, 1'b0, 3'b100}, {2'b00, 1'b0, 3'b000}, {2'b00, 1'b0, 3'b000}};
    logic [2:0] e;
    foreach (v[i]) begin
      drive(v[i][5:4], v[i][3], v[i][2:0]);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL back_to_back[%0d]: out=%b expected=%b", i, out, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      drive(2'b01, 1'b0, 3'b001);
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL async_setup_up[%0d]: out=%b expected=%b", pass, out, e);
      end
      if (pass == 1) begin
        drive(2'b00, 1'b1, 3'b100);
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
          miscompares++;
          $display("[TB] FAIL async_setup_door: out=%b expected=%b", out, e);
        end
        drive(2'b10, 1'b0, 3'b100);
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
          miscompares++;
          $display("[TB] FAIL async_setup_pending: out=%b expected=%b", out, e);
        end
      end
      #2;
      rst_n = 1'b0;
      motion_status = 2'b00;
      floor_status  = 1'b0;
      exp_q.push_back(3'b000);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("[TB] FAIL async_reset_immediate[%0d]: out=%b expected=%b", pass, out, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        drive(2'b00, 1'b0, 3'b000);
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
          miscompares++;
          $display("[TB] FAIL async_reset_after[%0d][%0d]: out=%b expected=%b", pass, i, out, e);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_move_and_door();
    test_pending_request();
    test_estop();
    test_ignore_while_moving();
    test_door_boundaries();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
